// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared PC widths, reset/exception vectors and redirect types
package cpu_pkg;

  localparam int PC_W = 30;
  localparam logic [PC_W-1:0] RESET_PC = 30'h00000C0D;
  localparam logic [PC_W-1:0] EXC_PC   = 30'h00000000;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PEND  = 2'd1,
    DRAIN = 2'd2
  } redir_state_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] target;
    logic            taken;
  } bht_upd_t;

endpackage

// File: rtl/bht_upd_fifo.sv
// rtl/bht_upd_fifo.sv - resolved-branch update queue feeding the BHT write port
module bht_upd_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     wr_valid_i,
  input  bht_upd_t wr_data_i,
  input  logic     rd_ready_i,
  output logic     rd_valid_o,
  output bht_upd_t rd_data_o,
  output logic     overflow_o
);

  localparam int AW = $clog2(DEPTH);

  bht_upd_t         mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW:0]      count_q;
  logic             overflow_q;
  logic             full;
  logic             do_enq;
  logic             do_deq;

  assign full       = (count_q == (AW+1)'(DEPTH));
  assign rd_valid_o = (count_q != '0);
  assign do_deq     = rd_valid_o && rd_ready_i;
  // A dequeue in the same cycle frees the slot, so a full queue still accepts.
  assign do_enq     = wr_valid_i && (!full || do_deq);

  always_ff @(posedge clk) begin
    if (do_enq) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_enq) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_deq) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + (AW+1)'(do_enq) - (AW+1)'(do_deq);
      if (wr_valid_i && !do_enq) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign rd_data_o  = mem_q[rd_ptr_q];
  assign overflow_o = overflow_q;

endmodule

// File: rtl/pc_redirect_ctrl.sv
// rtl/pc_redirect_ctrl.sv - fetch PC register, redirect arbitration and stage flushes
module pc_redirect_ctrl
  import cpu_pkg::*;
#(
  parameter int DRAIN_CYC = 2,
  parameter int UQ_DEPTH  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_if,
  input  logic            pred_valid,
  input  logic [PC_W-1:0] pred_pc,
  input  logic            id_jump_valid,
  input  logic [PC_W-1:0] id_jump_pc,
  input  logic            ex_br_valid,
  input  logic            ex_br_mispredict,
  input  logic [PC_W-1:0] ex_br_pc,
  input  logic [PC_W-1:0] ex_br_target,
  input  logic            ex_br_taken,
  input  logic            exc_valid,
  input  logic            eret_valid,
  input  logic [PC_W-1:0] epc,
  output logic [PC_W-1:0] pc,
  output logic            flush_if,
  output logic            flush_id,
  output logic            flush_ex,
  output logic            bht_upd_valid,
  output logic [PC_W-1:0] bht_upd_pc,
  output logic [PC_W-1:0] bht_upd_target,
  output logic            bht_upd_taken,
  input  logic            bht_upd_ready,
  output logic            uq_overflow
);

  localparam int CW = $clog2(DRAIN_CYC + 1);

  redir_state_e    state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pend_pc_q;
  logic [CW-1:0]   drain_cnt_q;
  logic            flush_if_q;
  logic            flush_id_q;
  logic            flush_ex_q;
  logic            br_redir;
  logic [PC_W-1:0] pc_inc;
  bht_upd_t        enq_data;
  bht_upd_t        head;

  assign br_redir = ex_br_valid && ex_br_mispredict;
  assign pc_inc   = pc_q + PC_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      pend_pc_q   <= '0;
      drain_cnt_q <= '0;
      flush_if_q  <= 1'b0;
      flush_id_q  <= 1'b0;
      flush_ex_q  <= 1'b0;
    end else begin
      flush_if_q <= 1'b0;
      flush_id_q <= 1'b0;
      flush_ex_q <= 1'b0;
      case (state_q)
        RUN, PEND: begin
          if (exc_valid || eret_valid) begin
            pc_q        <= exc_valid ? EXC_PC : epc;
            flush_if_q  <= 1'b1;
            flush_id_q  <= 1'b1;
            flush_ex_q  <= 1'b1;
            drain_cnt_q <= CW'(DRAIN_CYC - 1);
            state_q     <= DRAIN;
          end else if (br_redir) begin
            pc_q       <= ex_br_target;
            flush_if_q <= 1'b1;
            flush_id_q <= 1'b1;
            state_q    <= RUN;
          end else if (state_q == PEND) begin
            // The captured jump stays parked until fetch is released.
            if (!stall_if) begin
              pc_q       <= pend_pc_q;
              flush_if_q <= 1'b1;
              state_q    <= RUN;
            end
          end else if (id_jump_valid) begin
            if (stall_if) begin
              pend_pc_q <= id_jump_pc;
              state_q   <= PEND;
            end else begin
              pc_q       <= id_jump_pc;
              flush_if_q <= 1'b1;
            end
          end else if (!stall_if) begin
            pc_q <= pred_valid ? pred_pc : pc_inc;
          end
        end
        DRAIN: begin
          // Last drain cycle releases flushes and resumes sequential fetch.
          if (drain_cnt_q == '0) begin
            state_q <= RUN;
            if (!stall_if) begin
              pc_q <= pc_inc;
            end
          end else begin
            drain_cnt_q <= drain_cnt_q - CW'(1);
            flush_if_q  <= 1'b1;
            flush_id_q  <= 1'b1;
            flush_ex_q  <= 1'b1;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign enq_data = '{pc: ex_br_pc, target: ex_br_target, taken: ex_br_taken};

  bht_upd_fifo #(
    .DEPTH(UQ_DEPTH)
  ) u_uq (
    .clk        (clk),
    .rst        (rst),
    .wr_valid_i (ex_br_valid),
    .wr_data_i  (enq_data),
    .rd_ready_i (bht_upd_ready),
    .rd_valid_o (bht_upd_valid),
    .rd_data_o  (head),
    .overflow_o (uq_overflow)
  );

  assign pc             = pc_q;
  assign flush_if       = flush_if_q;
  assign flush_id       = flush_id_q;
  assign flush_ex       = flush_ex_q;
  assign bht_upd_pc     = head.pc;
  assign bht_upd_target = head.target;
  assign bht_upd_taken  = head.taken;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb/tb_pc_redirect_ctrl.sv - directed vector bench for pc_redirect_ctrl
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_if;
  logic        pred_valid;
  logic [29:0] pred_pc;
  logic        id_jump_valid;
  logic [29:0] id_jump_pc;
  logic        ex_br_valid;
  logic        ex_br_mispredict;
  logic [29:0] ex_br_pc;
  logic [29:0] ex_br_target;
  logic        ex_br_taken;
  logic        exc_valid;
  logic        eret_valid;
  logic [29:0] epc;
  logic [29:0] pc;
  logic        flush_if, flush_id, flush_ex;
  logic        bht_upd_valid;
  logic [29:0] bht_upd_pc, bht_upd_target;
  logic        bht_upd_taken;
  logic        bht_upd_ready;
  logic        uq_overflow;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pc_redirect_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .stall_if         (stall_if),
    .pred_valid       (pred_valid),
    .pred_pc          (pred_pc),
    .id_jump_valid    (id_jump_valid),
    .id_jump_pc       (id_jump_pc),
    .ex_br_valid      (ex_br_valid),
    .ex_br_mispredict (ex_br_mispredict),
    .ex_br_pc         (ex_br_pc),
    .ex_br_target     (ex_br_target),
    .ex_br_taken      (ex_br_taken),
    .exc_valid        (exc_valid),
    .eret_valid       (eret_valid),
    .epc              (epc),
    .pc               (pc),
    .flush_if         (flush_if),
    .flush_id         (flush_id),
    .flush_ex         (flush_ex),
    .bht_upd_valid    (bht_upd_valid),
    .bht_upd_pc       (bht_upd_pc),
    .bht_upd_target   (bht_upd_target),
    .bht_upd_taken    (bht_upd_taken),
    .bht_upd_ready    (bht_upd_ready),
    .uq_overflow      (uq_overflow)
  );

  typedef struct {
    logic        st;
    logic        pv;
    logic [29:0] ppc;
    logic        jv;
    logic [29:0] jpc;
    logic        bv;
    logic        bm;
    logic [29:0] bt;
    logic        ex;
    logic        er;
    logic [29:0] ep;
    logic [29:0] xpc;
    logic [2:0]  xfl;
  } vec_t;

  vec_t vecs[34];

  function automatic vec_t mk(input logic st, input logic pv, input logic [29:0] ppc,
                              input logic jv, input logic [29:0] jpc,
                              input logic bv, input logic bm, input logic [29:0] bt,
                              input logic ex, input logic er, input logic [29:0] ep,
                              input logic [29:0] xpc, input logic [2:0] xfl);
    vec_t v;
    v.st = st; v.pv = pv; v.ppc = ppc; v.jv = jv; v.jpc = jpc;
    v.bv = bv; v.bm = bm; v.bt = bt; v.ex = ex; v.er = er; v.ep = ep;
    v.xpc = xpc; v.xfl = xfl;
    return v;
  endfunction

  function automatic vec_t idle(input logic [29:0] xpc, input logic [2:0] xfl);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, xpc, xfl);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    stall_if = 0; pred_valid = 0; pred_pc = 0; id_jump_valid = 0; id_jump_pc = 0;
    ex_br_valid = 0; ex_br_mispredict = 0; ex_br_pc = 0; ex_br_target = 0;
    ex_br_taken = 0; exc_valid = 0; eret_valid = 0; epc = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = idle(30'h0C0E, 3'b000);
    vecs[1]  = idle(30'h0C0F, 3'b000);
    vecs[2]  = idle(30'h0C10, 3'b000);
    vecs[3]  = mk(0, 1, 30'h300, 1, 30'h200, 1, 1, 30'h100, 0, 0, 0, 30'h100, 3'b110);
    vecs[4]  = idle(30'h101, 3'b000);
    vecs[5]  = mk(1, 0, 0, 1, 30'h200, 0, 0, 0, 0, 0, 0, 30'h101, 3'b000);
    vecs[6]  = mk(1, 0, 0, 1, 30'h200, 0, 0, 0, 0, 0, 0, 30'h101, 3'b000);
    vecs[7]  = mk(1, 0, 0, 1, 30'h200, 0, 0, 0, 0, 0, 0, 30'h101, 3'b000);
    vecs[8]  = idle(30'h200, 3'b100);
    vecs[9]  = idle(30'h201, 3'b000);
    vecs[10] = mk(0, 0, 0, 0, 0, 1, 1, 30'h100, 1, 0, 0, 30'h0, 3'b111);
    vecs[11] = mk(0, 0, 0, 1, 30'h300, 0, 0, 0, 0, 0, 0, 30'h0, 3'b111);
    vecs[12] = idle(30'h1, 3'b000);
    vecs[13] = idle(30'h2, 3'b000);
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 30'h0C20, 30'h0C20, 3'b111);
    vecs[15] = idle(30'h0C20, 3'b111);
    vecs[16] = idle(30'h0C21, 3'b000);
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 30'h40, 30'h0, 3'b111);
    vecs[18] = idle(30'h0, 3'b111);
    vecs[19] = idle(30'h1, 3'b000);
    vecs[20] = mk(0, 1, 30'h3FFFFFFF, 0, 0, 0, 0, 0, 0, 0, 0, 30'h3FFFFFFF, 3'b000);
    vecs[21] = idle(30'h0, 3'b000);
    vecs[22] = mk(1, 1, 30'h55, 0, 0, 0, 0, 0, 0, 0, 0, 30'h0, 3'b000);
    vecs[23] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 30'h0, 3'b000);
    vecs[24] = mk(1, 0, 0, 0, 0, 1, 1, 30'h77, 0, 0, 0, 30'h77, 3'b110);
    vecs[25] = mk(0, 0, 0, 1, 30'h88, 0, 0, 0, 0, 0, 0, 30'h88, 3'b100);
    vecs[26] = mk(1, 0, 0, 1, 30'h99, 0, 0, 0, 0, 0, 0, 30'h88, 3'b000);
    vecs[27] = mk(1, 0, 0, 0, 0, 1, 1, 30'hAA, 0, 0, 0, 30'hAA, 3'b110);
    vecs[28] = idle(30'hAB, 3'b000);
    vecs[29] = mk(1, 0, 0, 1, 30'hBB, 0, 0, 0, 0, 0, 0, 30'hAB, 3'b000);
    vecs[30] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 30'h0, 3'b111);
    vecs[31] = idle(30'h0, 3'b111);
    vecs[32] = idle(30'h1, 3'b000);
    vecs[33] = mk(0, 1, 30'h10, 0, 0, 1, 0, 30'h99, 0, 0, 0, 30'h10, 3'b000);

    clear_inputs();
    bht_upd_ready = 1;
    rst = 1;
    tick();
    tick();
    chk("reset_pc", pc, 30'h0C0D);
    chk("reset_flush", {flush_if, flush_id, flush_ex}, 3'b000);
    chk("reset_uq_valid", bht_upd_valid, 0);
    chk("reset_overflow", uq_overflow, 0);
    rst = 0;

    for (int i = 0; i < 34; i++) begin
      stall_if = vecs[i].st; pred_valid = vecs[i].pv; pred_pc = vecs[i].ppc;
      id_jump_valid = vecs[i].jv; id_jump_pc = vecs[i].jpc;
      ex_br_valid = vecs[i].bv; ex_br_mispredict = vecs[i].bm; ex_br_target = vecs[i].bt;
      exc_valid = vecs[i].ex; eret_valid = vecs[i].er; epc = vecs[i].ep;
      tick();
      chk($sformatf("vec%0d_pc", i), pc, vecs[i].xpc);
      chk($sformatf("vec%0d_flush", i), {flush_if, flush_id, flush_ex}, vecs[i].xfl);
    end

    clear_inputs();
    tick();
    tick();
    chk("uq_empty_before_fill", bht_upd_valid, 0);

    // Five updates into a four-entry queue with the BHT port blocked.
    bht_upd_ready = 0;
    for (int i = 0; i < 5; i++) begin
      ex_br_valid = 1;
      ex_br_pc = 30'h10 + 30'(i);
      ex_br_target = 30'h20 + 30'(i);
      ex_br_taken = i[0];
      tick();
      if (i == 0) chk("uq_first_head_pc", bht_upd_pc, 30'h10);
      if (i == 3) chk("uq_full_no_overflow", uq_overflow, 0);
    end
    ex_br_valid = 0;
    chk("uq_overflow_set", uq_overflow, 1);
    bht_upd_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_valid", i), bht_upd_valid, 1);
      chk($sformatf("drain%0d_pc", i), bht_upd_pc, 30'h10 + 30'(i));
      chk($sformatf("drain%0d_target", i), bht_upd_target, 30'h20 + 30'(i));
      chk($sformatf("drain%0d_taken", i), bht_upd_taken, i[0]);
      tick();
    end
    chk("drain_empty", bht_upd_valid, 0);
    chk("overflow_sticky", uq_overflow, 1);

    // Full queue with simultaneous enqueue and dequeue keeps all entries.
    bht_upd_ready = 0;
    ex_br_taken = 1;
    for (int i = 0; i < 4; i++) begin
      ex_br_valid = 1;
      ex_br_pc = 30'h40 + 30'(i);
      ex_br_target = 30'h50 + 30'(i);
      tick();
    end
    ex_br_pc = 30'h44;
    ex_br_target = 30'h54;
    bht_upd_ready = 1;
    tick();
    ex_br_valid = 0;
    for (int i = 1; i < 5; i++) begin
      chk($sformatf("fullrw%0d_valid", i), bht_upd_valid, 1);
      chk($sformatf("fullrw%0d_pc", i), bht_upd_pc, 30'h40 + 30'(i));
      chk($sformatf("fullrw%0d_target", i), bht_upd_target, 30'h50 + 30'(i));
      tick();
    end
    chk("fullrw_empty", bht_upd_valid, 0);

    // Leave one entry queued, then reset in the middle of an exception drain.
    bht_upd_ready = 0;
    ex_br_valid = 1;
    exc_valid = 1;
    tick();
    ex_br_valid = 0;
    exc_valid = 0;
    chk("pre_reset_flush", {flush_if, flush_id, flush_ex}, 3'b111);
    chk("pre_reset_pc", pc, 30'h0);
    rst = 1;
    tick();
    rst = 0;
    chk("midrain_reset_pc", pc, 30'h0C0D);
    chk("midrain_reset_flush", {flush_if, flush_id, flush_ex}, 3'b000);
    chk("midrain_reset_uq_valid", bht_upd_valid, 0);
    chk("midrain_reset_overflow", uq_overflow, 0);
    tick();
    chk("post_reset_pc", pc, 30'h0C0E);
    chk("post_reset_flush", {flush_if, flush_id, flush_ex}, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
Central next-PC sequencer for the 5-stage pipeline. It owns the fetch PC register and arbitrates redirect requests from four sources: the predictor, ID-stage jumps (j/jal/jalr), EX-stage branch resolution, and CP0 (syscall/eret). It generates the per-stage flush signals. It also buffers resolved-branch outcomes in a small queue that drains into the single BHT write port.

Parameters:
PC_W, 30, word-address PC width
RESET_PC, 30'h00000C0D, fetch PC after reset (byte address 0x00003034)
EXC_PC, 30'h00000000, syscall vector (word address)
DRAIN_CYC, 2, cycles all flushes are held after an exception or eret
UQ_DEPTH, 4, BHT update queue entries (power of 2, ≥2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall_if  in  1  fetch stalled by hazard unit
pred_valid  in  1  predictor supplies target for current fetch
pred_pc  in  PC_W  predicted next PC
id_jump_valid  in  1  jump resolved in ID
id_jump_pc  in  PC_W  jump target
ex_br_valid  in  1  branch resolved in EX
ex_br_mispredict  in  1  resolution differs from prediction (qualified by ex_br_valid)
ex_br_pc  in  PC_W  PC of the branch instruction
ex_br_target  in  PC_W  correct next PC
ex_br_taken  in  1  actual direction
exc_valid  in  1  syscall taken
eret_valid  in  1  eret executed
epc  in  PC_W  return PC for eret
pc  out  PC_W  registered fetch PC
flush_if, flush_id, flush_ex  out  1  stage flushes (registered)
bht_upd_valid  out  1  queue head valid
bht_upd_pc, bht_upd_target  out  PC_W  head entry
bht_upd_taken  out  1  head entry direction
bht_upd_ready  in  1  BHT accepts head this cycle
uq_overflow  out  1  sticky: an update was dropped

Behaviour:
- Reset: pc=RESET_PC; all flushes 0; FSM=RUN; queue empty; bht_upd_valid=0; uq_overflow=0. Reset mid-drain or mid-pending aborts to this state.
- Redirect priority, evaluated each cycle in RUN: exc > eret > ex mispredict > id jump > pred > pc+1.
- Latency: a request accepted in cycle N gives pc=target and the corresponding flushes in cycle N+1, each flush lasting 1 cycle.
  - exc: target EXC_PC.
  - eret: target epc.
  - EX mispredict: target ex_br_target; flush_if and flush_id.
  - id jump: target id_jump_pc; flush_if only.
  - pred: target pred_pc; no flush.
- Stall handling:
  - exc, eret and EX mispredict ignore stall_if.
  - An id jump while stall_if=1 is captured and the FSM enters PEND; pc holds.
  - When stall_if falls: pc=captured target and flush_if=1, FSM returns to RUN.
  - A higher-priority redirect arriving in PEND overrides and discards the captured jump.
  - With no redirect and stall_if=1, pc holds; pred/pc+1 are not applied.
- Exceptions: exc or eret enters DRAIN (also from PEND). flush_if/id/ex are all 1 for DRAIN_CYC cycles starting N+1.
  - pc is held at the target during DRAIN.
  - All non-reset requests are ignored during DRAIN; the down-counter reaching 0 returns the FSM to RUN.
  - exc and eret in the same cycle: exc wins.
- Arithmetic: pc+1 wraps modulo 2^PC_W with no flag.
- Update queue:
  - Every ex_br_valid (mispredicted or not) enqueues {ex_br_pc, ex_br_target, ex_br_taken}, independent of FSM state, including DRAIN.
  - Dequeue on bht_upd_valid && bht_upd_ready. FIFO order.
  - Enqueue and dequeue in the same cycle with the queue full: both happen, count unchanged.
  - Enqueue when full with no dequeue: the entry is dropped and uq_overflow is set until reset.
  - Outputs come directly from the head register (no combinational path from inputs).

Decomposition:
- Shared package cpu_pkg: PC_W, RESET_PC, EXC_PC, enum redir_state_e {RUN, PEND, DRAIN}, struct bht_upd_t {pc, target, taken}.
- One sub-module: bht_upd_fifo (parameterised depth, valid/ready output, overflow flag).
- Arbitration, FSM and PC register stay in pc_redirect_ctrl.

Test Plan:
- Reset, then idle 3 cycles with no stall -> pc 0x0C0D, 0x0C0E, 0x0C0F, 0x0C10; all flushes 0.
- Same cycle: ex mispredict (target 0x100) + id jump (0x200) + pred (0x300) -> next cycle pc=0x100, flush_if=flush_id=1, flush_ex=0.
- id jump 0x200 with stall_if=1 for 3 cycles -> pc held, FSM=PEND; cycle after stall drops: pc=0x200, flush_if=1.
- exc + ex mispredict same cycle -> pc=0x0, all flushes 1 for 2 cycles; id jump during drain ignored; then pc=0x1.
- eret with epc=0x0C20, then 2 drain cycles -> pc=0x0C20 held 2 cycles, then 0x0C21.
- 5 consecutive ex_br_valid with bht_upd_ready=0 (depth 4) -> uq_overflow=1; raising ready drains entries 1–4 in order; 5th never appears.
